// File: rtl/wb_daq_channel_pk.sv
// Show-ahead word FIFO; head word visible combinationally, 0 when empty.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped and flagged.
module wb_daq_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          drop
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          pop_ok;
    logic          push_ok;

    assign empty    = (cnt == '0);
    assign full     = (cnt == FULL_CNT);
    assign pop_ok   = pop_vld & ~empty;
    // A pop in the same cycle frees the slot, so full+push+pop still lands the word.
    assign push_ok  = push_vld & (~full | pop_ok);
    assign drop     = push_vld & full & ~pop_ok;
    assign count    = cnt;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge wb_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// DAQ channel: decimate ADC samples, pack into 32-bit words, buffer, drain bursts of N words.
// Latency: word count rises the cycle after the completing strobe; start_sram rises one cycle after count>=N is seen.
// Backpressure: none toward the ADC; words arriving at a full FIFO are dropped and overflow is latched.
module wb_daq_channel_pk #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int AW           = 4
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst,
    input  logic                    master_enable,
    input  logic [31:0]             control,
    input  logic [AW:0]             fifo_number_samples_terminal,
    input  logic [SAMPLE_WIDTH-1:0] adc_data_out,
    input  logic                    adc_data_ready,
    input  logic                    data_done,
    output logic [31:0]             data_out,
    output logic                    start_sram,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic [AW:0]             fifo_count,
    output logic                    overflow
);
    localparam int LANES = 32 / SAMPLE_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [AW:0]   MAX_N     = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    logic          en;
    logic [7:0]    dec_factor;
    logic          ovf_clr;
    logic          ctrl_unused;
    logic [7:0]    dec_cnt;
    logic [LW-1:0] lane;
    logic [31:0]   word_q;
    logic [31:0]   pack_word;
    logic          accept;
    logic          push_vld;
    logic          pop_vld;
    logic          drop;
    logic          n_ok;
    state_t        state_q;
    state_t        state_d;
    logic [AW:0]   burst_left_q;
    logic [AW:0]   burst_left_d;

    assign en          = master_enable & control[0];
    assign ovf_clr     = control[1];
    assign dec_factor  = control[15:8];
    assign ctrl_unused = ^{control[31:16], control[7:2]};

    assign accept   = en & adc_data_ready & (dec_cnt == 8'd0);
    assign push_vld = accept & (lane == LAST_LANE);
    assign n_ok     = (fifo_number_samples_terminal != '0) &&
                      (fifo_number_samples_terminal <= MAX_N);

    // Drop the current sample into its lane; the first sample of a word lands in the LSBs.
    always_comb begin
        pack_word = word_q;
        pack_word[lane*SAMPLE_WIDTH +: SAMPLE_WIDTH] = adc_data_out;
    end

    // Decimation and lane tracking; disabling the channel discards the partial word.
    always_ff @(posedge wb_clk) begin
        if (wb_rst || !en) begin
            dec_cnt <= 8'd0;
            lane    <= '0;
            word_q  <= '0;
        end else if (adc_data_ready) begin
            if (dec_cnt == 8'd0) begin
                dec_cnt <= dec_factor;
                word_q  <= pack_word;
                lane    <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
            end else begin
                dec_cnt <= dec_cnt - 8'd1;
            end
        end
    end

    wb_daq_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .push_vld (push_vld),
        .push_dat (pack_word),
        .pop_vld  (pop_vld),
        .head_dat (data_out),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .drop     (drop)
    );

    // Burst sequencing: N is latched on entry, each data_done consumes one head word.
    always_comb begin
        state_d      = state_q;
        burst_left_d = burst_left_q;
        pop_vld      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (n_ok && (fifo_count >= fifo_number_samples_terminal)) begin
                    state_d      = S_BURST;
                    burst_left_d = fifo_number_samples_terminal;
                end
            end
            S_BURST: begin
                if (data_done) begin
                    pop_vld      = 1'b1;
                    burst_left_d = burst_left_q - (AW+1)'(1);
                    if (burst_left_q == (AW+1)'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state plus a registered burst request that follows the next state.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q      <= S_IDLE;
            burst_left_q <= '0;
            start_sram   <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_left_q <= burst_left_d;
            start_sram   <= (state_d == S_BURST);
        end
    end

    // Sticky overflow; a new drop outranks a concurrent clear.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_daq_channel_pk.sv
// Bench for wb_daq_channel_pk: directed scenarios on 8- and 16-bit channels plus a
// randomized run against a queue-based model of packing, FIFO occupancy and bursts.
module tb_wb_daq_channel_pk;
    localparam int DEPTH = 16;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        master_enable;
    logic [31:0] control;
    logic [4:0]  n_term;

    logic [7:0]  adc8;
    logic        rdy8, dd8, ss8, fe8, ff8, ovf8;
    logic [31:0] dout8;
    logic [4:0]  fc8;

    logic [15:0] adc16;
    logic        rdy16, dd16, ss16, fe16, ff16, ovf16;
    logic [31:0] dout16;
    logic [4:0]  fc16;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 wb_clk = ~wb_clk;

    wb_daq_channel_pk #(.SAMPLE_WIDTH(8), .FIFO_DEPTH(DEPTH), .AW(4)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .master_enable(master_enable), .control(control),
        .fifo_number_samples_terminal(n_term), .adc_data_out(adc8), .adc_data_ready(rdy8),
        .data_done(dd8), .data_out(dout8), .start_sram(ss8), .fifo_empty(fe8),
        .fifo_full(ff8), .fifo_count(fc8), .overflow(ovf8));

    wb_daq_channel_pk #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(DEPTH), .AW(4)) dut16 (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .master_enable(master_enable), .control(control),
        .fifo_number_samples_terminal(n_term), .adc_data_out(adc16), .adc_data_ready(rdy16),
        .data_done(dd16), .data_out(dout16), .start_sram(ss16), .fifo_empty(fe16),
        .fifo_full(ff16), .fifo_count(fc16), .overflow(ovf16));

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic strobe8(input logic [7:0] v);
        adc8 = v; rdy8 = 1'b1;
        tick();
        rdy8 = 1'b0;
    endtask

    task automatic strobe16(input logic [15:0] v);
        adc16 = v; rdy16 = 1'b1;
        tick();
        rdy16 = 1'b0;
    endtask

    task automatic do_reset();
        wb_rst = 1'b1; master_enable = 1'b0; control = 32'h0; n_term = 5'd0;
        adc8 = 8'h0; rdy8 = 1'b0; dd8 = 1'b0; adc16 = 16'h0; rdy16 = 1'b0; dd16 = 1'b0;
        tick(); tick();
        wb_rst = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst = 1'b1; master_enable = 1'b1; control = 32'h1; n_term = 5'd4;
        adc8 = 8'h55; rdy8 = 1'b1; dd8 = 1'b1; adc16 = 16'h0; rdy16 = 1'b0; dd16 = 1'b0;
        tick(); tick();
        n_checks++; if (dout8 !== 32'h0) $display("FAIL reset_data_out got %h want 0", dout8); else n_pass++;
        n_checks++; if (ss8 !== 1'b0) $display("FAIL reset_start_sram got %b want 0", ss8); else n_pass++;
        n_checks++; if (fe8 !== 1'b1) $display("FAIL reset_fifo_empty got %b want 1", fe8); else n_pass++;
        n_checks++; if (ff8 !== 1'b0) $display("FAIL reset_fifo_full got %b want 0", ff8); else n_pass++;
        n_checks++; if (fc8 !== 5'd0) $display("FAIL reset_fifo_count got %0d want 0", fc8); else n_pass++;
        n_checks++; if (ovf8 !== 1'b0) $display("FAIL reset_overflow got %b want 0", ovf8); else n_pass++;
        n_checks++; if (fe16 !== 1'b1) $display("FAIL reset_fifo_empty16 got %b want 1", fe16); else n_pass++;
        do_reset();
    endtask

    task automatic test_pack8_bursts();
        logic [31:0] exp_w;
        do_reset();
        master_enable = 1'b1; control = 32'h1; n_term = 5'd4;
        for (int i = 0; i < 16; i++) begin
            strobe8(8'(i));
            if (i == 2) begin
                n_checks++; if (fc8 !== 5'd0) $display("FAIL t1_count_after3 got %0d want 0", fc8); else n_pass++;
            end
            if (i == 3) begin
                n_checks++; if (fc8 !== 5'd1) $display("FAIL t1_count_after4 got %0d want 1", fc8); else n_pass++;
            end
        end
        n_checks++; if (fc8 !== 5'd4) $display("FAIL t1_count_4words got %0d want 4", fc8); else n_pass++;
        n_checks++; if (ss8 !== 1'b0) $display("FAIL t1_start_early got %b want 0", ss8); else n_pass++;
        tick();
        n_checks++; if (ss8 !== 1'b1) $display("FAIL t1_start_rise got %b want 1", ss8); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            n_checks++; if (dout8 !== exp_w) $display("FAIL t1_word%0d got %h want %h", k, dout8, exp_w); else n_pass++;
            dd8 = 1'b1; tick(); dd8 = 1'b0;
        end
        n_checks++; if (ss8 !== 1'b0) $display("FAIL t1_start_drop got %b want 0", ss8); else n_pass++;
        n_checks++; if (fe8 !== 1'b1) $display("FAIL t1_empty_end got %b want 1", fe8); else n_pass++;
    endtask

    task automatic test_pack16();
        do_reset();
        master_enable = 1'b1; control = 32'h1; n_term = 5'd4;
        strobe16(16'h0000);
        n_checks++; if (fc16 !== 5'd0) $display("FAIL t2_count_half got %0d want 0", fc16); else n_pass++;
        strobe16(16'h0001);
        n_checks++; if (fc16 !== 5'd1) $display("FAIL t2_count_one got %0d want 1", fc16); else n_pass++;
        strobe16(16'h0002); strobe16(16'h0003);
        n_checks++; if (fc16 !== 5'd2) $display("FAIL t2_count_two got %0d want 2", fc16); else n_pass++;
        dd16 = 1'b1; tick(); tick(); dd16 = 1'b0;
        n_checks++; if (fc16 !== 5'd2) $display("FAIL t2_idle_done_ignored got %0d want 2", fc16); else n_pass++;
        for (int i = 4; i < 8; i++) strobe16(16'(i));
        for (int i = 0; i < 8 && !ss16; i++) tick();
        n_checks++; if (ss16 !== 1'b1) $display("FAIL t2_start_timeout got %b want 1", ss16); else n_pass++;
        n_checks++; if (dout16 !== 32'h00010000) $display("FAIL t2_word0 got %h want 00010000", dout16); else n_pass++;
        dd16 = 1'b1; tick(); dd16 = 1'b0;
        n_checks++; if (dout16 !== 32'h00030002) $display("FAIL t2_word1 got %h want 00030002", dout16); else n_pass++;
    endtask

    task automatic test_decimation();
        do_reset();
        master_enable = 1'b1; control = 32'h0000_0201; n_term = 5'd4;
        for (int i = 0; i < 12; i++) strobe8(8'(i));
        n_checks++; if (fc8 !== 5'd1) $display("FAIL t3_count got %0d want 1", fc8); else n_pass++;
        n_checks++; if (dout8 !== 32'h09060300) $display("FAIL t3_word got %h want 09060300", dout8); else n_pass++;
    endtask

    task automatic test_overflow_and_full_pushpop();
        do_reset();
        master_enable = 1'b1; control = 32'h1; n_term = 5'd17;
        for (int i = 0; i < 64; i++) strobe8(8'(i));
        n_checks++; if (ff8 !== 1'b1) $display("FAIL t4_full got %b want 1", ff8); else n_pass++;
        n_checks++; if (ovf8 !== 1'b0) $display("FAIL t4_no_ovf_yet got %b want 0", ovf8); else n_pass++;
        for (int i = 64; i < 68; i++) strobe8(8'(i));
        n_checks++; if (ovf8 !== 1'b1) $display("FAIL t4_ovf_set got %b want 1", ovf8); else n_pass++;
        n_checks++; if (fc8 !== 5'd16) $display("FAIL t4_count_cap got %0d want 16", fc8); else n_pass++;
        n_checks++; if (ss8 !== 1'b0) $display("FAIL t4_no_start_n17 got %b want 0", ss8); else n_pass++;
        n_checks++; if (dout8 !== 32'h03020100) $display("FAIL t4_head_kept got %h want 03020100", dout8); else n_pass++;
        control = 32'h3; tick(); control = 32'h1;
        n_checks++; if (ovf8 !== 1'b0) $display("FAIL t4_ovf_clear got %b want 0", ovf8); else n_pass++;
        control = 32'h3;
        for (int i = 0; i < 4; i++) strobe8(8'hA0);
        control = 32'h1;
        n_checks++; if (ovf8 !== 1'b1) $display("FAIL t4_set_beats_clear got %b want 1", ovf8); else n_pass++;
        control = 32'h3; tick(); control = 32'h1;
        n_term = 5'd16;
        for (int i = 0; i < 8 && !ss8; i++) tick();
        n_checks++; if (ss8 !== 1'b1) $display("FAIL t6_start_timeout got %b want 1", ss8); else n_pass++;
        strobe8(8'h11); strobe8(8'h22); strobe8(8'h33);
        dd8 = 1'b1; strobe8(8'h44); dd8 = 1'b0;
        n_checks++; if (fc8 !== 5'd16) $display("FAIL t6_full_pushpop_count got %0d want 16", fc8); else n_pass++;
        n_checks++; if (ovf8 !== 1'b0) $display("FAIL t6_full_pushpop_ovf got %b want 0", ovf8); else n_pass++;
        n_checks++; if (dout8 !== 32'h07060504) $display("FAIL t6_head_after_pop got %h want 07060504", dout8); else n_pass++;
        wb_rst = 1'b1; tick();
        n_checks++; if (ss8 !== 1'b0) $display("FAIL t6_rst_start got %b want 0", ss8); else n_pass++;
        n_checks++; if (fe8 !== 1'b1) $display("FAIL t6_rst_empty got %b want 1", fe8); else n_pass++;
        wb_rst = 1'b0;
    endtask

    task automatic test_disable();
        do_reset();
        master_enable = 1'b1; control = 32'h1; n_term = 5'd4;
        strobe8(8'hAA); strobe8(8'hBB);
        control = 32'h0; strobe8(8'hFF); control = 32'h1;
        strobe8(8'h10); strobe8(8'h11); strobe8(8'h12);
        n_checks++; if (fc8 !== 5'd0) $display("FAIL t5_no_stale_word got %0d want 0", fc8); else n_pass++;
        strobe8(8'h13);
        n_checks++; if (dout8 !== 32'h13121110) $display("FAIL t5_fresh_word got %h want 13121110", dout8); else n_pass++;
        dd8 = 1'b1; tick(); tick(); dd8 = 1'b0;
        n_checks++; if (fc8 !== 5'd1) $display("FAIL t5_idle_done got %0d want 1", fc8); else n_pass++;
        master_enable = 1'b0; strobe8(8'h20); strobe8(8'h21); master_enable = 1'b1;
        for (int i = 0; i < 4; i++) strobe8(8'(8'h30 + i));
        n_checks++; if (fc8 !== 5'd2) $display("FAIL t5_me_count got %0d want 2", fc8); else n_pass++;
    endtask

    // Model: FIFO as a queue of words, samples collected until a word is complete,
    // decimation as "every (D+1)-th strobe since enable", bursts as N pops after count>=N.
    task automatic test_random();
        logic [31:0] q[$];
        logic [7:0]  part[$];
        logic [31:0] exp_dout, w;
        logic        exp_ss, nss, exp_ovf, en, clr, stb, dd, drop;
        logic [7:0]  smp;
        int          sidx, rem, d, n;
        for (int seg = 0; seg < 5; seg++) begin
            do_reset();
            d = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                8:       n = 0;
                9:       n = 17;
                default: n = $urandom_range(1, 8);
            endcase
            if (seg == 0) n = 16;
            n_term = 5'(n);
            q.delete(); part.delete();
            sidx = 0; rem = 0; exp_ss = 1'b0; exp_ovf = 1'b0;
            for (int cyc = 0; cyc < 500; cyc++) begin
                exp_dout = (q.size() != 0) ? q[0] : 32'h0;
                n_checks++; if (ss8 !== exp_ss) $display("FAIL rnd_start seg%0d cyc%0d got %b want %b", seg, cyc, ss8, exp_ss); else n_pass++;
                n_checks++; if (dout8 !== exp_dout) $display("FAIL rnd_data seg%0d cyc%0d got %h want %h", seg, cyc, dout8, exp_dout); else n_pass++;
                n_checks++; if (fc8 !== 5'(q.size())) $display("FAIL rnd_count seg%0d cyc%0d got %0d want %0d", seg, cyc, fc8, q.size()); else n_pass++;
                n_checks++; if (fe8 !== (q.size() == 0)) $display("FAIL rnd_empty seg%0d cyc%0d got %b", seg, cyc, fe8); else n_pass++;
                n_checks++; if (ff8 !== (q.size() == DEPTH)) $display("FAIL rnd_full seg%0d cyc%0d got %b", seg, cyc, ff8); else n_pass++;
                n_checks++; if (ovf8 !== exp_ovf) $display("FAIL rnd_ovf seg%0d cyc%0d got %b want %b", seg, cyc, ovf8, exp_ovf); else n_pass++;

                en  = ($urandom_range(0, 31) != 0);
                clr = ($urandom_range(0, 63) == 0);
                stb = ($urandom_range(0, 2) != 0);
                dd  = $urandom_range(0, 1);
                smp = 8'($urandom);
                drop = 1'b0;

                nss = exp_ss;
                if (exp_ss) begin
                    if (dd) begin
                        rem--;
                        if (rem == 0) nss = 1'b0;
                    end
                end else if (n != 0 && n <= DEPTH && q.size() >= n) begin
                    nss = 1'b1;
                    rem = n;
                end
                if (exp_ss && dd) void'(q.pop_front());
                if (!en) begin
                    part.delete();
                    sidx = 0;
                end else if (stb) begin
                    if (sidx % (d + 1) == 0) begin
                        part.push_back(smp);
                        if (part.size() == 4) begin
                            w = {part[3], part[2], part[1], part[0]};
                            if (q.size() < DEPTH) q.push_back(w);
                            else drop = 1'b1;
                            part.delete();
                        end
                    end
                    sidx++;
                end
                if (drop) exp_ovf = 1'b1;
                else if (clr) exp_ovf = 1'b0;
                exp_ss = nss;

                if (!en && $urandom_range(0, 1) == 1) begin
                    master_enable = 1'b0; control = {16'h0, 8'(d), 6'b0, clr, 1'b1};
                end else begin
                    master_enable = 1'b1; control = {16'h0, 8'(d), 6'b0, clr, en};
                end
                adc8 = smp; rdy8 = stb; dd8 = dd;
                tick();
            end
            rdy8 = 1'b0; dd8 = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pack8_bursts();
        test_pack16();
        test_decimation();
        test_disable();
        test_overflow_and_full_pushpop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
